// File: rtl/ex_stage_muldiv.sv
// Execute stage: forwarding, ALU, branch target, dest select,
// plus an iterative MULT/DIV unit with HI/LO and a stall to hazard logic.
module ex_stage_muldiv #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rd_data1,
  input  logic [XLEN-1:0] rd_data2,
  input  logic [XLEN-1:0] imm,
  input  logic [REGW-1:0] rt,
  input  logic [REGW-1:0] rd,
  input  logic [XLEN-1:0] fwd_mem,
  input  logic [XLEN-1:0] fwd_wb,
  input  logic [1:0]      fwd_a_sel,
  input  logic [1:0]      fwd_b_sel,
  input  logic            alu_src,
  input  logic            reg_dst,
  input  logic [3:0]      alu_op,
  input  logic [3:0]      md_op,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] branch_target,
  output logic [REGW-1:0] dest_reg,
  output logic            stall,
  output logic            md_busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   acc_hi;
  logic [XLEN-1:0]   acc_lo;
  logic [XLEN-1:0]   opb;
  logic              neg_p;
  logic              neg_r;
  logic              div0;

  logic [XLEN-1:0]   a;
  logic [XLEN-1:0]   bf;
  logic [XLEN-1:0]   b;
  logic [XLEN-1:0]   alu_y;
  logic              md_any;
  logic              start_op;
  logic              is_mul;
  logic              sgn;
  logic              start;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN:0]     msum;
  logic [XLEN:0]     dtrial;
  logic [XLEN-1:0]   nxt_hi;
  logic [XLEN-1:0]   nxt_lo;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   q_fix;
  logic [XLEN-1:0]   r_fix;

  always_comb begin
    unique case (fwd_a_sel)
      2'd1:    a = fwd_wb;
      2'd2:    a = fwd_mem;
      default: a = rd_data1;
    endcase
    unique case (fwd_b_sel)
      2'd1:    bf = fwd_wb;
      2'd2:    bf = fwd_mem;
      default: bf = rd_data2;
    endcase
  end

  assign b          = alu_src ? imm : bf;
  assign store_data = bf;

  always_comb begin
    unique case (alu_op)
      4'd0:    alu_y = a & b;
      4'd1:    alu_y = a | b;
      4'd2:    alu_y = a + b;
      4'd6:    alu_y = a - b;
      4'd7:    alu_y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      4'd12:   alu_y = ~(a | b);
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    unique case (1'b1)
      md_op == 4'd5: result = hi;
      md_op == 4'd6: result = lo;
      default:       result = alu_y;
    endcase
  end

  assign zero          = (result == '0);
  assign branch_target = pc + {imm[XLEN-3:0], 2'b00};
  assign dest_reg      = reg_dst ? rd : rt;

  assign md_any   = (md_op >= 4'd1) && (md_op <= 4'd8);
  assign start_op = (md_op >= 4'd1) && (md_op <= 4'd4);
  assign is_mul   = (md_op == 4'd1) || (md_op == 4'd2);
  assign sgn      = (md_op == 4'd1) || (md_op == 4'd3);
  assign stall    = in_valid & md_busy & md_any;
  assign start    = in_valid & start_op & ~stall & (state == S_IDLE);

  assign mag_a = (sgn && a[XLEN-1]) ? -a : a;
  assign mag_b = (sgn && bf[XLEN-1]) ? -bf : bf;

  // One iteration: shift-add for MUL, restoring subtract for DIV
  always_comb begin
    msum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    dtrial = {acc_hi, acc_lo[XLEN-1]} - {1'b0, opb};
    if (state == S_MUL) begin
      nxt_hi = msum[XLEN:1];
      nxt_lo = {msum[0], acc_lo[XLEN-1:1]};
    end else if (!dtrial[XLEN]) begin
      nxt_hi = dtrial[XLEN-1:0];
      nxt_lo = {acc_lo[XLEN-2:0], 1'b1};
    end else begin
      nxt_hi = {acc_hi[XLEN-2:0], acc_lo[XLEN-1]};
      nxt_lo = {acc_lo[XLEN-2:0], 1'b0};
    end
  end

  assign prod     = {nxt_hi, nxt_lo};
  assign prod_fix = neg_p ? -prod : prod;
  assign q_fix    = div0 ? '1 : (neg_p ? -nxt_lo : nxt_lo);
  assign r_fix    = neg_r ? -nxt_hi : nxt_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      md_busy <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opb     <= '0;
      neg_p   <= 1'b0;
      neg_r   <= 1'b0;
      div0    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            cnt     <= CNT_INIT;
            md_busy <= 1'b1;
            acc_hi  <= '0;
            neg_r   <= sgn & a[XLEN-1];
            neg_p   <= sgn & (a[XLEN-1] ^ bf[XLEN-1]);
            div0    <= (bf == '0);
            if (is_mul) begin
              state  <= S_MUL;
              acc_lo <= mag_b;
              opb    <= mag_a;
            end else begin
              state  <= S_DIV;
              acc_lo <= mag_a;
              opb    <= mag_b;
            end
          end else if (in_valid && !stall && md_op == 4'd7) begin
            hi <= a;
          end else if (in_valid && !stall && md_op == 4'd8) begin
            lo <= a;
          end
        end
        default: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt - 1'b1;
          if (cnt == CNT_LAST) begin
            state   <= S_IDLE;
            md_busy <= 1'b0;
            if (state == S_MUL) begin
              hi <= prod_fix[2*XLEN-1:XLEN];
              lo <= prod_fix[XLEN-1:0];
            end else begin
              hi <= r_fix;
              lo <= q_fix;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Scoreboard bench for ex_stage_muldiv: directed vectors,
// expectations queued by stimulus, checked by a negedge monitor.
module tb_ex_stage_muldiv;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  localparam int K_RES = 0;
  localparam int K_SD  = 1;
  localparam int K_BT  = 2;
  localparam int K_STL = 3;
  localparam int K_HL  = 4;
  localparam int K_DST = 5;
  localparam int K_Z   = 6;
  localparam int K_BSY = 7;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rd_data1;
  logic [XLEN-1:0] rd_data2;
  logic [XLEN-1:0] imm;
  logic [REGW-1:0] rt;
  logic [REGW-1:0] rd;
  logic [XLEN-1:0] fwd_mem;
  logic [XLEN-1:0] fwd_wb;
  logic [1:0]      fwd_a_sel;
  logic [1:0]      fwd_b_sel;
  logic            alu_src;
  logic            reg_dst;
  logic [3:0]      alu_op;
  logic [3:0]      md_op;
  logic [XLEN-1:0] result;
  logic            zero;
  logic [XLEN-1:0] store_data;
  logic [XLEN-1:0] branch_target;
  logic [REGW-1:0] dest_reg;
  logic            stall;
  logic            md_busy;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  ex_stage_muldiv #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .pc(pc),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .imm(imm),
    .rt(rt), .rd(rd), .fwd_mem(fwd_mem), .fwd_wb(fwd_wb),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .alu_src(alu_src), .reg_dst(reg_dst), .alu_op(alu_op),
    .md_op(md_op), .result(result), .zero(zero),
    .store_data(store_data), .branch_target(branch_target),
    .dest_reg(dest_reg), .stall(stall), .md_busy(md_busy),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          kind;
    logic [63:0] exp;
  } chk_t;

  chk_t cq[$];
  chk_t hq[$];
  chk_t me;
  int   nvec = 0;
  int   nbad = 0;
  int   busy_n = 0;
  logic prev_busy = 1'b0;

  logic [31:0] fwd_r [4] = '{32'h4, 32'h23, 32'h13, 32'h4};
  logic [31:0] fwd_s [4] = '{32'h55, 32'h20, 32'h10, 32'h55};
  logic [3:0]  alu_ops [6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd12, 4'd3};
  logic [31:0] alu_exp [6] = '{32'h30, 32'hFC, 32'h12C,
                               32'hB4, 32'hFFFFFF03, 32'h0};

  task automatic compare(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] actual(int k);
    case (k)
      K_RES:   return 64'(result);
      K_SD:    return 64'(store_data);
      K_BT:    return 64'(branch_target);
      K_STL:   return 64'(stall);
      K_HL:    return {hi, lo};
      K_DST:   return 64'(dest_reg);
      K_Z:     return 64'(zero);
      K_BSY:   return 64'(md_busy);
      default: return 64'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    while (cq.size() > 0) begin
      me = cq.pop_front();
      compare(me.name, actual(me.kind), me.exp);
    end
    if (md_busy) busy_n++;
    if (prev_busy && !md_busy && rst_n) begin
      if (hq.size() == 0) begin
        nvec++;
        nbad++;
        $display("FAIL md_done: got completion want none");
      end else begin
        me = hq.pop_front();
        compare(me.name, {hi, lo}, me.exp);
        compare({me.name, "_cycles"}, 64'(busy_n), 64'(XLEN));
      end
      busy_n = 0;
    end
    if (!rst_n) busy_n = 0;
    prev_busy = md_busy;
  end

  task automatic expc(string nm, int k, logic [63:0] v);
    chk_t c;
    c.name = nm;
    c.kind = k;
    c.exp  = v;
    cq.push_back(c);
  endtask

  task automatic exph(string nm, logic [63:0] v);
    chk_t c;
    c.name = nm;
    c.kind = K_HL;
    c.exp  = v;
    hq.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    md_op    = 4'd0;
  endtask

  task automatic drive(logic [3:0] op, logic [31:0] x, logic [31:0] y);
    in_valid  = 1'b1;
    md_op     = op;
    fwd_a_sel = 2'd0;
    fwd_b_sel = 2'd0;
    alu_src   = 1'b0;
    rd_data1  = x;
    rd_data2  = y;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && hq.size() > 0; i++) step();
    if (hq.size() > 0) begin
      nvec++;
      nbad++;
      $display("FAIL md_timeout: got %0d pending want 0", hq.size());
      hq.delete();
    end
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b1;
    pc = '0;
    rd_data1 = '0;
    rd_data2 = '0;
    imm = '0;
    rt = 5'd3;
    rd = 5'd9;
    fwd_mem = '0;
    fwd_wb = '0;
    fwd_a_sel = 2'd0;
    fwd_b_sel = 2'd0;
    alu_src = 1'b0;
    reg_dst = 1'b0;
    alu_op = 4'd2;
    md_op = 4'd5;
    expc("rst_hilo", K_HL, 64'h0);
    expc("rst_busy", K_BSY, 64'h0);
    expc("rst_stall", K_STL, 64'h0);
    step();
    step();
    rst_n = 1'b1;
    idle();
    step();

    in_valid = 1'b1;
    rd_data1 = 32'h1;
    rd_data2 = 32'h55;
    fwd_mem  = 32'h10;
    fwd_wb   = 32'h20;
    imm      = 32'h3;
    alu_src  = 1'b1;
    alu_op   = 4'd2;
    for (int i = 0; i < 4; i++) begin
      fwd_a_sel = 2'(i);
      fwd_b_sel = 2'(i);
      expc($sformatf("fwd_a%0d", i), K_RES, 64'(fwd_r[i]));
      expc($sformatf("fwd_b%0d", i), K_SD, 64'(fwd_s[i]));
      step();
    end

    drive(4'd0, 32'hF0, 32'h3C);
    for (int i = 0; i < 6; i++) begin
      alu_op = alu_ops[i];
      expc($sformatf("alu_op%0d", alu_ops[i]), K_RES, 64'(alu_exp[i]));
      expc($sformatf("zero_op%0d", alu_ops[i]), K_Z,
           64'(alu_exp[i] == 32'h0));
      step();
    end
    drive(4'd0, 32'hFFFFFFFF, 32'h1);
    alu_op = 4'd7;
    expc("slt_neg", K_RES, 64'h1);
    step();
    drive(4'd0, 32'h1, 32'hFFFFFFFF);
    expc("slt_pos", K_RES, 64'h0);
    reg_dst = 1'b0;
    expc("dest_rt", K_DST, 64'd3);
    step();
    reg_dst = 1'b1;
    expc("dest_rd", K_DST, 64'd9);
    pc  = 32'h1000;
    imm = 32'hFFFFFFFF;
    expc("bt_back", K_BT, 64'h0FFC);
    step();
    pc  = 32'hFFFFFFFC;
    imm = 32'h1;
    expc("bt_wrap", K_BT, 64'h0);
    step();

    drive(4'd1, 32'hFFFFFFFD, 32'h5);
    exph("mult_m3x5", 64'hFFFFFFFF_FFFFFFF1);
    step();
    drive(4'd6, 32'h0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      expc($sformatf("mflo_stall%0d", i), K_STL, 64'h1);
      step();
    end
    expc("mflo_release", K_STL, 64'h0);
    expc("mflo_val", K_RES, 64'hFFFFFFF1);
    step();
    md_op = 4'd5;
    expc("mfhi_val", K_RES, 64'hFFFFFFFF);
    step();

    drive(4'd2, 32'hFFFFFFFF, 32'h2);
    exph("multu_ffx2", 64'h00000001_FFFFFFFE);
    step();
    drive(4'd0, 32'h5, 32'h6);
    alu_op = 4'd2;
    expc("add_busy_stall", K_STL, 64'h0);
    expc("add_busy_res", K_RES, 64'd11);
    expc("add_busy_flag", K_BSY, 64'h1);
    step();
    idle();
    wait_done();

    drive(4'd4, 32'd100, 32'd7);
    exph("divu_100_7", {32'd2, 32'd14});
    step();
    idle();
    wait_done();
    drive(4'd3, 32'hFFFFFFF9, 32'd2);
    exph("div_m7_2", 64'hFFFFFFFF_FFFFFFFD);
    step();
    idle();
    wait_done();
    drive(4'd3, 32'd5, 32'd0);
    exph("div_5_0", 64'h00000005_FFFFFFFF);
    step();
    idle();
    wait_done();
    drive(4'd3, 32'h80000000, 32'hFFFFFFFF);
    exph("div_min_m1", 64'h00000000_80000000);
    step();
    idle();
    wait_done();

    drive(4'd1, 32'd2, 32'd3);
    exph("b2b_first", 64'd6);
    step();
    drive(4'd1, 32'd4, 32'd5);
    exph("b2b_second", 64'd20);
    for (int i = 0; i < 32; i++) begin
      expc($sformatf("b2b_stall%0d", i), K_STL, 64'h1);
      step();
    end
    expc("b2b_start", K_STL, 64'h0);
    step();
    idle();
    wait_done();

    drive(4'd8, 32'h1234, 32'h0);
    step();
    drive(4'd7, 32'hABCD, 32'h0);
    step();
    drive(4'd6, 32'h0, 32'h0);
    expc("mtlo_val", K_RES, 64'h1234);
    step();
    md_op = 4'd5;
    expc("mthi_val", K_RES, 64'hABCD);
    step();

    drive(4'd4, 32'd100, 32'd7);
    step();
    idle();
    repeat (10) step();
    #2;
    rst_n = 1'b0;
    in_valid = 1'b1;
    md_op = 4'd5;
    expc("abort_busy", K_BSY, 64'h0);
    expc("abort_stall", K_STL, 64'h0);
    expc("abort_hilo", K_HL, 64'h0);
    step();
    rst_n = 1'b1;
    expc("post_rst_mfhi", K_RES, 64'h0);
    expc("post_rst_stall", K_STL, 64'h0);
    step();
    idle();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ex_stage_muldiv.md
# ex_stage_muldiv

Parametrised execute stage for the five-stage pipeline: operand forwarding, ALU-source selection, combinational ALU, branch-target adder and destination-register select. It adds an iterative multiply/divide unit with HI/LO registers and a stall output toward the hazard unit. It sits between the ID/EX and EX/MEM pipeline registers. Single-cycle ops complete combinationally; MULT/DIV run in the background for XLEN cycles.

## Interface
- XLEN, 32, datapath width (even, ≥8)
- REGW, 5, register-index width

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  ID/EX holds a valid instruction
- pc  in  XLEN  PC+4 of instruction
- rd_data1, rd_data2  in  XLEN  register-file read data
- imm  in  XLEN  sign-extended immediate
- rt, rd  in  REGW  candidate destination indices
- fwd_mem, fwd_wb  in  XLEN  forwarded EX/MEM and MEM/WB results
- fwd_a_sel, fwd_b_sel  in  2  0 = register, 1 = fwd_wb, 2 = fwd_mem, 3 = register
- alu_src  in  1  1 = operand B is imm
- reg_dst  in  1  1 = dest is rd, else rt
- alu_op  in  4  0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT (signed), 12 NOR, others → 0
- md_op  in  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9–15 none
- result  out  XLEN  ALU result, or HI/LO for MFHI/MFLO
- zero  out  1  result == 0
- store_data  out  XLEN  forwarded operand B before the alu_src mux
- branch_target  out  XLEN  pc + (imm << 2), mod 2^XLEN
- dest_reg  out  REGW  selected destination
- stall  out  1  hold ID/EX and earlier stages; insert a bubble into EX/MEM
- md_busy  out  1  multiply/divide iteration in progress
- hi, lo  out  XLEN  architectural HI/LO registers

## Operation
- A = fwd-muxed rd_data1. Bf = fwd-muxed rd_data2. B = alu_src ? imm : Bf. store_data = Bf.
- The MUL/DIV unit always takes A and Bf as operands (never imm).
- FSM states:
  - IDLE: start when in_valid & md_op∈{1..4} & !stall. Latch operands and load a counter with XLEN. Go to MUL (1,2) or DIV (3,4).
  - MUL: radix-2 shift-add on operand magnitudes, one bit per cycle.
  - DIV: restoring division on magnitudes, one quotient bit per cycle.
  - On the final iteration edge, write HI/LO with sign-corrected results and return to IDLE.
- MULT/MULTU: {HI,LO} = 2·XLEN-bit product. Signed mode treats operands as two's complement.
- DIV/DIVU: LO = quotient (truncated toward zero), HI = remainder.
  - Signed mode: quotient is negative iff operand signs differ; remainder takes the dividend's sign.
  - Divisor 0: LO = all ones, HI = dividend, still XLEN cycles.
  - Signed MIN / −1: LO = MIN, HI = 0.
- MTHI/MTLO: write A into HI/LO at the clock edge when in_valid & !stall.
- MFHI/MFLO: result = hi/lo; alu_op ignored.
- stall = in_valid & md_busy & md_op∈{1..8}. Start, MF and MT ops all wait for the unit. ALU-only ops never stall.
- The start instruction itself does not stall; it leaves EX in its issue cycle with result = ALU output (don't-care to the pipeline).
- While stall is high, no MT write and no new start occur. Outputs track the held inputs.

## Timing
- Reset (async assert, sync release): FSM = IDLE, counter = 0, hi = lo = 0, md_busy = 0, hence stall = 0.
- Reset mid-operation aborts the operation. HI/LO read 0 afterwards.
- result, zero, store_data, branch_target, dest_reg and stall are combinational from inputs and state; no added latency.
- md_busy rises on the edge after the start edge and stays high exactly XLEN cycles.
- HI/LO update on the edge that drops md_busy.
- An MFLO presented in the cycle immediately after the start sees stall = 1 for exactly XLEN cycles, then reads the new LO.
- Back-to-back MULT: the second stalls XLEN cycles, then starts in the cycle md_busy falls.
- An MT op in the same cycle the unit completes is stalled, because md_busy is still high during that cycle. HI/LO then update once from the unit and once, on the next edge, from the MT op.

## Test plan
- Forwarding: rd_data1 = 1, fwd_mem = 0x10, fwd_wb = 0x20, alu_op = ADD, B = imm = 3. Expected: fwd_a_sel 0/1/2/3 → result 4/0x23/0x13/4. store_data follows fwd_b_sel.
- MULT −3 × 5 (XLEN = 32) → after 32 busy cycles, HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. MULTU 0xFFFFFFFF × 2 → HI = 1, LO = 0xFFFFFFFE.
- DIVU 100/7 → LO = 14, HI = 2. DIV −7/2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 5/0 → LO = 0xFFFFFFFF, HI = 5. DIV 0x80000000/−1 → LO = 0x80000000, HI = 0.
- MFLO issued in the cycle after MULT start → stall high exactly 32 cycles; the next cycle result = new LO with stall = 0. ADD issued during busy → no stall.
- Assert rst_n low asynchronously 10 cycles into a DIV → md_busy, stall, hi, lo = 0 immediately. After release, MFHI returns 0 with no stall.
- Branch target: pc = 0x1000, imm = 0xFFFFFFFF → branch_target = 0x0FFC. pc = 0xFFFFFFFC, imm = 1 → branch_target = 0 (wrap).
